memory_loader: RTL and testbench
================================

# memory_loader

Write-side initiator for the 1K×16 instruction/data memory. Accepts a stream of 16-bit words on a valid/ready handshake, writes them to consecutive addresses starting at a programmable base via the memory's `addr`/`din`/`wea` port, then reads each word back and checks it. Sits between the boot/host interface and `memory`, and owns the memory write port while `busy` is high. Fetch and decode only use the memory after `done`.

## Interface
Parameters:
- `ADDR_W`, 10: memory address width.
- `DATA_W`, 16: word width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low; 0 resets all state.
- `start`, in, 1: begin a load; sampled only in IDLE.
- `base`, in, ADDR_W: first write address; latched on accepted `start`.
- `length`, in, ADDR_W+1: word count, 0..1024; latched on accepted `start`.
- `in_valid`, in, 1: source has a word.
- `in_data`, in, DATA_W: word to load.
- `in_ready`, out, 1: loader will accept a word this cycle.
- `addr`, out, ADDR_W: memory address.
- `din`, out, DATA_W: memory write data.
- `wea`, out, 1: memory write enable.
- `douta`, in, DATA_W: memory read data; registered, 1-cycle latency from `addr`.
- `busy`, out, 1: load in progress.
- `done`, out, 1: one-cycle pulse at the end of a load.
- `error`, out, 1: readback mismatch on the last load; sticky until the next accepted `start`.
- `err_addr`, out, ADDR_W: address of the first mismatch.

## Operation
- States: IDLE, WAIT, WRITE, READ, CHECK, DONE. All outputs are registered.
- Reset values: state IDLE. `addr`, `din`, `err_addr` = 0. `wea`, `in_ready`, `busy`, `done`, `error` = 0.
- IDLE, `start`=1:
  - Latch `base` and `length`; set word index to 0; clear `error` and `err_addr`.
  - If `length`=0, go to DONE. Otherwise go to WAIT.
- WAIT: `in_ready`=1. When `in_valid`&&`in_ready`, latch `in_data` and go to WRITE.
- WRITE: `addr`=base+idx, `din`=latched word, `wea`=1. Go to READ.
- READ: `wea`=0, same `addr`. Go to CHECK.
- CHECK: compare `douta` with the latched word.
  - Mismatch: set `error`=1, `err_addr`=`addr`, go to DONE (the load is aborted).
  - Match, with idx+1 = `length`: go to DONE.
  - Match otherwise: increment idx and go to WAIT.
- DONE: `done`=1 for one cycle, `busy`=0, then go to IDLE.
- `busy`=1 in WAIT, WRITE, READ and CHECK.
- Address arithmetic is modulo 2^ADDR_W: base+idx wraps from 1023 to 0.
- A load with `length`=1024 writes every location exactly once.
- `start` outside IDLE is ignored. `in_valid` outside WAIT is ignored; no word is consumed.
- `reset` asserted mid-load drops `wea` and `in_ready` immediately, without waiting for a clock edge. The partial load is abandoned and `done` is not pulsed.

## Timing
- `start` sampled at edge E: `busy`=1 and `in_ready`=1 from E+1.
- Handshake at edge H:
  - WRITE (`wea`=1) during H..H+1; the memory writes at H+1.
  - READ during H+1..H+2.
  - CHECK during H+2..H+3; `douta` is valid in this window and is compared at H+3.
- Next `in_ready`=1 at H+3. Peak throughput is one word per 4 cycles.
- Last word: `done`=1 during H+3..H+4, then `busy`=0.
- `length`=0: `done` asserts at E+1, with no `wea` and no `in_ready`.
- A source that holds `in_valid` high sees exactly one transfer per WAIT cycle in which `in_ready` is high.

## Structure
- Shared package `loader_pkg`:
  - State enumeration (3-bit encoding).
  - Default `ADDR_W`/`DATA_W` constants; the memory and fetch unit use the same constants.
- Single module. No sub-module is needed: the index counter and the address adder are inline.

## Test plan
- Reset, then `base`=1, `length`=3, words 0x1000 / 0x8C00 / 0xAC00 → mem[1..3] hold those words, `wea` pulses 3 times, `done` pulses once, `error`=0.
- `base`=1022, `length`=4, words 0xA..0xD → writes go to 1022, 1023, 0, 1 in that order; `done`=1, `error`=0.
- `length`=0 → `done` asserts the cycle after `start`; `wea` and `in_ready` are never 1.
- Memory model corrupts location 5, `base`=4, `length`=3 → `error`=1, `err_addr`=5, `done` pulses, and the third word is never accepted (`in_ready` stays 0).
- `in_valid` toggled randomly, plus `start` re-pulsed while `busy` → the word order and count written are exactly those of the handshakes; the second `start` has no effect.
- `reset`=0 during WRITE of word 2 → `wea`=0 with no clock edge, all outputs at reset values; a later load from IDLE completes normally.

Source files
------------

// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared constants and types for the memory loader and the blocks that share
// the 1K x 16 instruction/data memory (memory, fetch unit).
//   DEFAULT_ADDR_W : memory address width (1024 words)
//   DEFAULT_DATA_W : memory word width
//   state_t        : loader FSM states, 3-bit encoding
// ---------------------------------------------------------------------------
package loader_pkg;

    localparam int DEFAULT_ADDR_W = 10;
    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/memory_loader.sv
// ---------------------------------------------------------------------------
// memory_loader
// Write-side initiator for the instruction/data memory. Takes a stream of
// words on a valid/ready handshake, writes each one to base+idx, reads it
// back one cycle later and compares. Owns the memory write port while busy.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low; 0 clears all state
//   start     in   begin a load (only looked at in IDLE)
//   base      in   first write address, latched on accepted start
//   length    in   word count 0..2^ADDR_W, latched on accepted start
//   in_valid  in   source has a word
//   in_data   in   word to load
//   in_ready  out  loader accepts a word this cycle
//   addr      out  memory address
//   din       out  memory write data
//   wea       out  memory write enable
//   douta     in   memory read data, one cycle after addr
//   busy      out  load in progress
//   done      out  one-cycle pulse at the end of a load
//   error     out  readback mismatch on the last load (sticky)
//   err_addr  out  address of the first mismatch
// ---------------------------------------------------------------------------
module memory_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   length,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] din,
    output logic              wea,
    input  logic [DATA_W-1:0] douta,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr
);

    state_t state;
    state_t next_state;

    // Index and length are one bit wider than the address so that a full
    // 2^ADDR_W-word load can be counted and compared without overflow.
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] base_d;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_d;
    logic [ADDR_W:0]   idx_q;
    logic [ADDR_W:0]   idx_d;
    logic [ADDR_W:0]   idx_inc;

    logic [DATA_W-1:0] din_d;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] err_addr_d;
    logic              error_d;
    logic              in_ready_d;
    logic              wea_d;
    logic              busy_d;
    logic              done_d;

    logic              handshake;
    logic              mismatch;
    logic              last_word;

    // din doubles as the latched word, so the readback compares against it.
    assign handshake = (state == ST_WAIT) && in_valid && in_ready;
    assign mismatch  = (douta != din);
    assign idx_inc   = idx_q + (ADDR_W+1)'(1);
    assign last_word = (idx_inc == len_q);

    // State register plus the registered copies of every output, so all
    // outputs leave the block straight from flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            din      <= '0;
            addr     <= '0;
            err_addr <= '0;
            error    <= 1'b0;
            in_ready <= 1'b0;
            wea      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= next_state;
            base_q   <= base_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            din      <= din_d;
            addr     <= addr_d;
            err_addr <= err_addr_d;
            error    <= error_d;
            in_ready <= in_ready_d;
            wea      <= wea_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // Next-state logic. A mismatch aborts the load straight to DONE.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = (length == '0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (handshake) begin
                    next_state = ST_WRITE;
                end
            end
            ST_WRITE: next_state = ST_READ;
            ST_READ:  next_state = ST_CHECK;
            ST_CHECK: begin
                if (mismatch || last_word) begin
                    next_state = ST_DONE;
                end else begin
                    next_state = ST_WAIT;
                end
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath. Control outputs
    // are decoded from next_state so they line up with the state they
    // describe; the address wraps naturally at ADDR_W bits.
    always_comb begin
        base_d     = base_q;
        len_d      = len_q;
        idx_d      = idx_q;
        din_d      = din;
        addr_d     = addr;
        error_d    = error;
        err_addr_d = err_addr;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    base_d     = base;
                    len_d      = length;
                    idx_d      = '0;
                    error_d    = 1'b0;
                    err_addr_d = '0;
                end
            end
            ST_WAIT: begin
                if (handshake) begin
                    din_d  = in_data;
                    addr_d = base_q + idx_q[ADDR_W-1:0];
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    error_d    = 1'b1;
                    err_addr_d = addr;
                end else if (!last_word) begin
                    idx_d = idx_inc;
                end
            end
            default: begin
            end
        endcase

        in_ready_d = (next_state == ST_WAIT);
        wea_d      = (next_state == ST_WRITE);
        done_d     = (next_state == ST_DONE);
        busy_d     = (next_state == ST_WAIT)  || (next_state == ST_WRITE) ||
                     (next_state == ST_READ)  || (next_state == ST_CHECK);
    end

endmodule

// File: tb/tb_memory_loader.sv
// ---------------------------------------------------------------------------
// tb_memory_loader
// Self-checking bench for memory_loader. A behavioural 1K x 16 memory with a
// registered read port (and an optional corrupted location) sits on the
// loader's memory port. Expected writes are queued as handshakes complete
// and compared against the writes the memory actually received.
// ---------------------------------------------------------------------------
module tb_memory_loader;
    import loader_pkg::*;

    localparam int AW = DEFAULT_ADDR_W;
    localparam int DW = DEFAULT_DATA_W;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   length;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          wea;
    logic [DW-1:0] douta;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] err_addr;

    // Memory model and observation counters (written only by the monitor)
    logic [DW-1:0]    mem [0:(1<<AW)-1];
    logic             corrupt_en;
    logic [AW-1:0]    corrupt_addr;
    logic [AW+DW-1:0] obs_q [$];
    int               hs_count    = 0;
    int               done_count  = 0;
    int               ready_count = 0;

    // Scoreboard and result counters (written only by the stimulus block)
    logic [AW+DW-1:0] exp_q [$];
    int               obs_rd = 0;
    logic [AW-1:0]    model_base;
    int               model_idx;
    int               checks = 0;
    int               errors = 0;

    memory_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base     (base),
        .length   (length),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .addr     (addr),
        .din      (din),
        .wea      (wea),
        .douta    (douta),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_addr (err_addr)
    );

    always #5 clk = ~clk;

    // Memory with registered read; a corrupted location stores inverted data.
    always @(posedge clk) begin
        if (wea === 1'b1) begin
            mem[addr] <= (corrupt_en && addr == corrupt_addr) ? ~din : din;
            obs_q.push_back({addr, din});
        end
        douta <= mem[addr];
        if (in_valid === 1'b1 && in_ready === 1'b1) hs_count <= hs_count + 1;
        if (done === 1'b1) done_count <= done_count + 1;
        if (in_ready === 1'b1) ready_count <= ready_count + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Pulse start for one edge; returns at the negedge after that edge.
    task automatic apply_stimulus(input logic [AW-1:0] b, input logic [AW:0] len);
        start  = 1'b1;
        base   = b;
        length = len;
        model_base = b;
        model_idx  = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one word until it is taken; queue its expected write.
    task automatic send_word(input logic [DW-1:0] w);
        int  h0;
        bit  ok;
        h0 = hs_count;
        ok = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (hs_count != h0) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        check_output("handshake_taken", {31'b0, ok}, 32'd1);
        if (ok) begin
            exp_q.push_back({AW'(model_base + AW'(model_idx)), w});
            model_idx++;
        end
    endtask

    task automatic wait_done(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (done === 1'b1) break;
            @(negedge clk);
        end
        check_output("done_seen", {31'b0, done}, 32'd1);
    endtask

    // Match every observed memory write against the expected queue in order.
    task automatic sb_drain();
        logic [AW+DW-1:0] e;
        while (obs_rd < obs_q.size()) begin
            check_output("sb_has_entry", {31'b0, (exp_q.size() != 0)}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_output("wr_addr", {22'b0, obs_q[obs_rd][AW+DW-1:DW]}, {22'b0, e[AW+DW-1:DW]});
                check_output("wr_data", {16'b0, obs_q[obs_rd][DW-1:0]}, {16'b0, e[DW-1:0]});
            end
            obs_rd++;
        end
        check_output("sb_leftover", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] words [0:5];
        int d0;
        int w0;
        int r0;
        int h0;

        reset        = 1'b0;
        start        = 1'b0;
        base         = '0;
        length       = '0;
        in_valid     = 1'b0;
        in_data      = '0;
        corrupt_en   = 1'b0;
        corrupt_addr = '0;
        model_base   = '0;
        model_idx    = 0;

        // Reset values
        #1;
        check_output("rst_addr",     {22'b0, addr},     32'd0);
        check_output("rst_din",      {16'b0, din},      32'd0);
        check_output("rst_err_addr", {22'b0, err_addr}, 32'd0);
        check_output("rst_ctrl", {27'b0, wea, in_ready, busy, done, error}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Basic load: base 1, three words
        $display("[TB] basic load base=1 length=3");
        d0 = done_count;
        w0 = obs_q.size();
        apply_stimulus(10'd1, 11'd3);
        check_output("start_busy",  {31'b0, busy},     32'd1);
        check_output("start_ready", {31'b0, in_ready}, 32'd1);
        send_word(16'h1000);
        check_output("write_wea", {31'b0, wea}, 32'd1);
        @(negedge clk);
        check_output("read_wea", {31'b0, wea}, 32'd0);
        send_word(16'h8C00);
        send_word(16'hAC00);
        repeat (2) @(negedge clk);
        check_output("last_check_done", {31'b0, done}, 32'd0);
        check_output("last_check_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check_output("last_done", {31'b0, done}, 32'd1);
        check_output("last_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check_output("done_one_cycle", {31'b0, done}, 32'd0);
        check_output("basic_error", {31'b0, error}, 32'd0);
        check_output("basic_done_count", done_count - d0, 32'd1);
        check_output("basic_wea_count", obs_q.size() - w0, 32'd3);
        check_output("mem1", {16'b0, mem[1]}, 32'h1000);
        check_output("mem2", {16'b0, mem[2]}, 32'h8C00);
        check_output("mem3", {16'b0, mem[3]}, 32'hAC00);
        sb_drain();

        // Address wrap: base 1022, four words
        $display("[TB] wrap load base=1022 length=4");
        apply_stimulus(10'd1022, 11'd4);
        for (int k = 0; k < 4; k++) send_word(16'hA + 16'(k));
        wait_done(10);
        check_output("wrap_error", {31'b0, error}, 32'd0);
        sb_drain();
        check_output("mem1022", {16'b0, mem[1022]}, 32'h000A);
        check_output("mem1023", {16'b0, mem[1023]}, 32'h000B);
        check_output("mem0",    {16'b0, mem[0]},    32'h000C);
        check_output("mem1w",   {16'b0, mem[1]},    32'h000D);
        repeat (2) @(negedge clk);

        // Zero-length load
        $display("[TB] zero-length load");
        r0 = ready_count;
        w0 = obs_q.size();
        in_valid = 1'b1;
        apply_stimulus(10'd5, 11'd0);
        check_output("len0_done",  {31'b0, done},     32'd1);
        check_output("len0_ready", {31'b0, in_ready}, 32'd0);
        check_output("len0_wea",   {31'b0, wea},      32'd0);
        @(negedge clk);
        check_output("len0_done_drop", {31'b0, done}, 32'd0);
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        check_output("len0_no_ready", ready_count - r0, 32'd0);
        check_output("len0_no_write", obs_q.size() - w0, 32'd0);

        // Readback mismatch at location 5
        $display("[TB] corrupted location 5");
        corrupt_en   = 1'b1;
        corrupt_addr = 10'd5;
        d0 = done_count;
        apply_stimulus(10'd4, 11'd3);
        send_word(16'h1111);
        send_word(16'h2222);
        h0 = hs_count;
        r0 = ready_count;
        in_data  = 16'h3333;
        in_valid = 1'b1;
        wait_done(10);
        check_output("err_flag", {31'b0, error},    32'd1);
        check_output("err_addr", {22'b0, err_addr}, 32'd5);
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        check_output("err_no_third_hs", hs_count - h0, 32'd0);
        check_output("err_no_ready", ready_count - r0, 32'd0);
        check_output("err_done_count", done_count - d0, 32'd1);
        check_output("err_sticky", {31'b0, error}, 32'd1);
        sb_drain();
        corrupt_en = 1'b0;

        // Random in_valid with a stray start while busy
        $display("[TB] random valid with re-pulsed start");
        words[0] = 16'h0101; words[1] = 16'h0202; words[2] = 16'h0303;
        words[3] = 16'h0404; words[4] = 16'h0505; words[5] = 16'h0606;
        d0 = done_count;
        apply_stimulus(10'd100, 11'd6);
        check_output("restart_clears_error", {31'b0, error}, 32'd0);
        check_output("restart_clears_err_addr", {22'b0, err_addr}, 32'd0);
        h0 = hs_count;
        for (int it = 0; it < 400; it++) begin
            if (hs_count - h0 != model_idx) begin
                exp_q.push_back({AW'(model_base + AW'(model_idx)), words[model_idx]});
                model_idx++;
            end
            if (model_idx >= 6) break;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = words[model_idx];
            if (it == 9) begin
                start  = 1'b1;
                base   = 10'd500;
                length = 11'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check_output("rand_hs_count", hs_count - h0, 32'd6);
        wait_done(10);
        repeat (3) @(negedge clk);
        check_output("rand_idle_after", {31'b0, busy}, 32'd0);
        check_output("rand_done_count", done_count - d0, 32'd1);
        check_output("rand_error", {31'b0, error}, 32'd0);
        sb_drain();

        // Reset during the write of word 2, then a clean load
        $display("[TB] reset mid-load");
        d0 = done_count;
        apply_stimulus(10'd10, 11'd3);
        send_word(16'h5A5A);
        send_word(16'hA5A5);
        check_output("pre_reset_wea", {31'b0, wea}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check_output("async_wea",   {31'b0, wea},      32'd0);
        check_output("async_ready", {31'b0, in_ready}, 32'd0);
        check_output("async_ctrl",  {29'b0, busy, done, error}, 32'd0);
        check_output("async_addr",  {22'b0, addr}, 32'd0);
        check_output("async_din",   {16'b0, din},  32'd0);
        void'(exp_q.pop_back());
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_output("abort_no_done", done_count - d0, 32'd0);
        sb_drain();
        apply_stimulus(10'd20, 11'd2);
        send_word(16'hC0DE);
        send_word(16'hBEEF);
        wait_done(10);
        check_output("post_reset_error", {31'b0, error}, 32'd0);
        check_output("mem20", {16'b0, mem[20]}, 32'hC0DE);
        check_output("mem21", {16'b0, mem[21]}, 32'hBEEF);
        @(negedge clk);
        sb_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
